// File: rtl/dma_wb_writer.sv
// dma_wb_writer
//   Write-back DMA engine. Result words from the accelerator stream are
//   queued in a small FIFO and written to the SDRAM controller DMA port as
//   single-word Wishbone writes at consecutive word addresses.
//
// Ports
//   wb_clk_i, wb_rst_n_i     clock (rising edge), async active-low reset
//   start_i                  one-cycle pulse that starts a transfer (IDLE only)
//   base_adr_i               byte address of first word; bits [1:0] are dropped
//   len_i                    number of words to transfer (0 = no-op transfer)
//   acc_valid_i/acc_data_i   accelerator result stream
//   acc_ready_o              word accepted when acc_valid_i && acc_ready_o
//   dram_fun_sel_o           high while this engine owns the SDRAM DMA port
//   dram_wbs_*               Wishbone master towards the SDRAM controller
//   busy_o                   transfer in progress
//   done_o                   one-cycle pulse when a transfer completes
module dma_wb_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  start_i,
    input  logic [31:0]           base_adr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  acc_valid_i,
    input  logic [DATA_WIDTH-1:0] acc_data_i,
    output logic                  acc_ready_o,
    output logic                  dram_fun_sel_o,
    output logic                  dram_wbs_cyc_o,
    output logic                  dram_wbs_stb_o,
    output logic                  dram_wbs_we_o,
    output logic [3:0]            dram_wbs_sel_o,
    output logic [31:0]           dram_wbs_adr_o,
    output logic [DATA_WIDTH-1:0] dram_wbs_dat_o,
    input  logic                  dram_wbs_ack_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, WRITE, DONE} state_t;

    state_t                 state;
    logic [31:0]            adr;
    logic [LEN_WIDTH-1:0]   wr_remaining;
    logic [LEN_WIDTH-1:0]   acc_remaining;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic                   in_xfer;
    logic                   push;
    logic                   pop;

    // Ready is decoded from registers only, so the accelerator can never
    // form a combinational loop through acc_valid_i.
    assign in_xfer     = (state == WAIT_DATA) || (state == WRITE);
    assign acc_ready_o = in_xfer && (count != FULL_CNT) && (acc_remaining != '0);
    assign push        = acc_valid_i && acc_ready_o;
    // stb is only ever high in WRITE, so this also filters stray acks.
    assign pop         = dram_wbs_stb_o && dram_wbs_ack_i;

    assign dram_fun_sel_o = busy_o;

    // NOTE: FIFO storage has no reset; count alone decides which entries are
    // valid, so clearing count on reset is enough to discard stale words.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= acc_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state          <= IDLE;
            adr            <= '0;
            wr_remaining   <= '0;
            acc_remaining  <= '0;
            dram_wbs_cyc_o <= 1'b0;
            dram_wbs_stb_o <= 1'b0;
            dram_wbs_we_o  <= 1'b0;
            dram_wbs_sel_o <= 4'h0;
            dram_wbs_adr_o <= '0;
            dram_wbs_dat_o <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            // push is only possible in WAIT_DATA/WRITE, so this never
            // collides with the length load in IDLE.
            if (push) acc_remaining <= acc_remaining - LEN_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            adr           <= base_adr_i & ~32'd3;
                            wr_remaining  <= len_i;
                            acc_remaining <= len_i;
                            busy_o        <= 1'b1;
                            state         <= WAIT_DATA;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (count != '0) begin
                        dram_wbs_adr_o <= adr;
                        dram_wbs_dat_o <= mem[rd_ptr];
                        dram_wbs_cyc_o <= 1'b1;
                        dram_wbs_stb_o <= 1'b1;
                        dram_wbs_we_o  <= 1'b1;
                        dram_wbs_sel_o <= 4'hF;
                        state          <= WRITE;
                    end
                end

                WRITE: begin
                    // Bus outputs hold until the slave acknowledges.
                    if (dram_wbs_ack_i) begin
                        dram_wbs_cyc_o <= 1'b0;
                        dram_wbs_stb_o <= 1'b0;
                        dram_wbs_we_o  <= 1'b0;
                        dram_wbs_sel_o <= 4'h0;
                        adr            <= adr + 32'd4;
                        wr_remaining   <= wr_remaining - LEN_WIDTH'(1);
                        if (wr_remaining == LEN_WIDTH'(1)) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end

                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_wb_writer.sv
// Testbench for dma_wb_writer.
//   A negedge monitor holds a transaction-level model of the engine (counts
//   of words accepted and written, transfer active, done pending) and checks
//   the status outputs every cycle; it pushes the expected (address, data) of
//   every accepted word into a scoreboard. A Wishbone slave process pops the
//   scoreboard for each strobe and acknowledges after a random delay.
module tb_dma_wb_writer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = 16;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n_i;
    logic          start_i;
    logic [31:0]   base_adr_i;
    logic [LW-1:0] len_i;
    logic          acc_valid_i;
    logic [DW-1:0] acc_data_i;
    logic          acc_ready_o;
    logic          dram_fun_sel_o;
    logic          dram_wbs_cyc_o;
    logic          dram_wbs_stb_o;
    logic          dram_wbs_we_o;
    logic [3:0]    dram_wbs_sel_o;
    logic [31:0]   dram_wbs_adr_o;
    logic [DW-1:0] dram_wbs_dat_o;
    logic          dram_wbs_ack_i;
    logic          busy_o;
    logic          done_o;

    always #5 wb_clk_i = ~wb_clk_i;

    dma_wb_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_n_i     (wb_rst_n_i),
        .start_i        (start_i),
        .base_adr_i     (base_adr_i),
        .len_i          (len_i),
        .acc_valid_i    (acc_valid_i),
        .acc_data_i     (acc_data_i),
        .acc_ready_o    (acc_ready_o),
        .dram_fun_sel_o (dram_fun_sel_o),
        .dram_wbs_cyc_o (dram_wbs_cyc_o),
        .dram_wbs_stb_o (dram_wbs_stb_o),
        .dram_wbs_we_o  (dram_wbs_we_o),
        .dram_wbs_sel_o (dram_wbs_sel_o),
        .dram_wbs_adr_o (dram_wbs_adr_o),
        .dram_wbs_dat_o (dram_wbs_dat_o),
        .dram_wbs_ack_i (dram_wbs_ack_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit          active;      // transfer in progress after the last edge
    bit          done_now;    // done pulse expected after the last edge
    int          acc_cnt;     // words accepted in this transfer
    int          wr_cnt;      // words acknowledged in this transfer
    int          xlen;
    logic [31:0] base_m;
    int          done_cnt;
    bit          accept_flag; // a word is accepted at the coming edge
    bit          cyc_seen;
    bit          saw_full;
    bit          nd;
    bit          exp_rdy;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] words[$];

    // Slave knobs
    int ack_min, ack_max;
    bit hold_ack, spurious_en;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            active   = 1'b0;
            done_now = 1'b0;
            acc_cnt  = 0;
            wr_cnt   = 0;
        end
        exp_rdy = active && ((acc_cnt - wr_cnt) < DEPTH) && (acc_cnt < xlen);
        check("busy",      busy_o,         active);
        check("fun_sel",   dram_fun_sel_o, active);
        check("done",      done_o,         done_now);
        check("acc_ready", acc_ready_o,    exp_rdy);
        if (dram_wbs_cyc_o) cyc_seen = 1'b1;
        if (active && (acc_cnt - wr_cnt) == DEPTH) saw_full = 1'b1;

        accept_flag = acc_valid_i && acc_ready_o && wb_rst_n_i;
        nd = 1'b0;
        if (wb_rst_n_i) begin
            if (start_i && !active && !done_now) begin
                if (len_i == '0) begin
                    nd = 1'b1;
                end else begin
                    active  = 1'b1;
                    xlen    = int'(len_i);
                    acc_cnt = 0;
                    wr_cnt  = 0;
                    base_m  = base_adr_i & ~32'd3;
                end
            end else if (active) begin
                if (acc_valid_i && acc_ready_o) begin
                    exp_adr_q.push_back(base_m + 32'(acc_cnt * 4));
                    exp_dat_q.push_back(acc_data_i);
                    acc_cnt++;
                end
                if (dram_wbs_stb_o && dram_wbs_ack_i) begin
                    wr_cnt++;
                    if (wr_cnt == xlen) begin
                        active = 1'b0;
                        nd     = 1'b1;
                    end
                end
            end
        end
        done_now = nd;
        if (nd) done_cnt++;
    end

    // ---------------- Wishbone slave / scoreboard consumer ----------------
    logic [31:0] s_adr, s_dat, e_adr, e_dat;
    int          delay;
    bit          abort;

    initial begin
        dram_wbs_ack_i = 1'b0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (!wb_rst_n_i) begin
                dram_wbs_ack_i = 1'b0;
            end else if (dram_wbs_stb_o && !dram_wbs_ack_i) begin
                s_adr = dram_wbs_adr_o;
                s_dat = dram_wbs_dat_o;
                if (exp_adr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e_adr = exp_adr_q.pop_front();
                    e_dat = exp_dat_q.pop_front();
                    check("wr_adr", s_adr, e_adr);
                    check("wr_dat", s_dat, e_dat);
                end
                check("wr_cyc_we_sel", {dram_wbs_cyc_o, dram_wbs_we_o, dram_wbs_sel_o}, 6'h3F);
                delay = $urandom_range(ack_min, ack_max);
                abort = 1'b0;
                for (int c = 0; c < 1000 && (c < delay || hold_ack); c++) begin
                    @(posedge wb_clk_i);
                    #1;
                    if (!wb_rst_n_i) begin
                        abort = 1'b1;
                        break;
                    end
                    check("stable_adr", dram_wbs_adr_o, s_adr);
                    check("stable_dat", dram_wbs_dat_o, s_dat);
                    check("stable_stb", dram_wbs_stb_o, 1);
                end
                if (!abort) begin
                    dram_wbs_ack_i = 1'b1;
                    @(posedge wb_clk_i);
                    #1;
                    dram_wbs_ack_i = 1'b0;
                    if (wb_rst_n_i) check("stb_drop", dram_wbs_stb_o, 0);
                end else begin
                    dram_wbs_ack_i = 1'b0;
                end
            end else if (spurious_en && !dram_wbs_stb_o && $urandom_range(0, 3) == 0) begin
                dram_wbs_ack_i = 1'b1;
                @(posedge wb_clk_i);
                #1;
                dram_wbs_ack_i = 1'b0;
            end
        end
    end

    // ---------------- accelerator stream driver ----------------
    task automatic drive(input int n, input int extra, input bit hold);
        bit got;
        for (int i = 0; i < n + extra; i++) begin
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    acc_valid_i = 1'b0;
                    @(posedge wb_clk_i);
                    #1;
                end
            end
            acc_valid_i = 1'b1;
            acc_data_i  = (i < n) ? words[i] : $urandom;
            if (i < n) begin
                got = 1'b0;
                for (int c = 0; c < 400; c++) begin
                    @(posedge wb_clk_i);
                    #1;
                    if (!wb_rst_n_i) begin
                        acc_valid_i = 1'b0;
                        return;
                    end
                    if (accept_flag) begin
                        got = 1'b1;
                        break;
                    end
                end
                if (!got) check("accept_timeout", 0, 1);
            end else begin
                repeat (6) begin
                    @(posedge wb_clk_i);
                    #1;
                    check("extra_not_accepted", accept_flag, 0);
                end
            end
        end
        acc_valid_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] base, input int len);
        @(posedge wb_clk_i);
        #1;
        start_i    = 1'b1;
        base_adr_i = base;
        len_i      = LW'(len);
        @(posedge wb_clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] base, input int len, input int extra,
                            input bit hold, input bit mid_start);
        int target;
        target = done_cnt + 1;
        fork
            drive(len, extra, hold);
        join_none
        if (mid_start) begin
            fork
                begin
                    repeat (4) @(posedge wb_clk_i);
                    #1;
                    if (active) begin
                        start_i = 1'b1;
                        len_i   = LW'(5);
                        @(posedge wb_clk_i);
                        #1;
                        start_i = 1'b0;
                    end
                end
            join_none
        end
        pulse_start(base, len);
        for (int c = 0; c < 3000 && done_cnt < target; c++) @(posedge wb_clk_i);
        check("done_seen", done_cnt >= target, 1);
        wait fork;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("done_once", done_cnt - target, 0);
        check("sb_empty", exp_adr_q.size(), 0);
        check("idle_after", busy_o, 0);
    endtask

    initial begin
        wb_rst_n_i  = 1'b0;
        start_i     = 1'b0;
        base_adr_i  = '0;
        len_i       = '0;
        acc_valid_i = 1'b0;
        acc_data_i  = '0;
        ack_min     = 0;
        ack_max     = 0;
        hold_ack    = 1'b0;
        spurious_en = 1'b0;
        done_cnt    = 0;
        xlen        = 0;

        #2;
        check("rst_ctrl", {acc_ready_o, dram_fun_sel_o, dram_wbs_cyc_o, dram_wbs_stb_o,
                           dram_wbs_we_o, dram_wbs_sel_o, busy_o, done_o}, 0);
        check("rst_adr", dram_wbs_adr_o, 0);
        check("rst_dat", dram_wbs_dat_o, 0);
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;

        // Basic transfer, ack in the first strobe cycle.
        words = '{32'hA1, 32'hA2, 32'hA3};
        run_xfer(32'h0000_1000, 3, 0, 1'b0, 1'b0);

        // Backpressure: FIFO must fill, a 9th word must never be taken.
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back(32'hB0 + i);
        ack_min  = 10;
        ack_max  = 10;
        saw_full = 1'b0;
        run_xfer(32'h0000_2000, 8, 1, 1'b1, 1'b0);
        check("fifo_filled", saw_full, 1);

        // Zero length: done only, no bus cycle.
        ack_min  = 0;
        ack_max  = 2;
        cyc_seen = 1'b0;
        words.delete();
        run_xfer(32'h0000_3000, 0, 1, 1'b0, 1'b0);
        check("zero_len_no_cyc", cyc_seen, 0);

        // Start mid-transfer is ignored.
        words = '{32'hC1, 32'hC2, 32'hC3};
        ack_min = 3;
        ack_max = 5;
        run_xfer(32'h0000_4000, 3, 0, 1'b0, 1'b1);

        // Alignment and address wrap.
        ack_min = 0;
        ack_max = 1;
        words = '{32'hD1, 32'hD2};
        run_xfer(32'hFFFF_FFFE, 2, 0, 1'b0, 1'b0);

        // Reset while a strobe is outstanding.
        hold_ack = 1'b1;
        words = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
        fork
            drive(4, 0, 1'b1);
        join_none
        pulse_start(32'h0000_0100, 4);
        for (int c = 0; c < 100 && !dram_wbs_stb_o; c++) begin
            @(posedge wb_clk_i);
            #1;
        end
        check("stb_before_reset", dram_wbs_stb_o, 1);
        #3;
        wb_rst_n_i = 1'b0;
        #1;
        check("mid_rst_ctrl", {acc_ready_o, dram_fun_sel_o, dram_wbs_cyc_o, dram_wbs_stb_o,
                               dram_wbs_we_o, dram_wbs_sel_o, busy_o, done_o}, 0);
        check("mid_rst_adr", dram_wbs_adr_o, 0);
        check("mid_rst_dat", dram_wbs_dat_o, 0);
        wait fork;
        exp_adr_q.delete();
        exp_dat_q.delete();
        hold_ack = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;
        words = '{32'h55};
        run_xfer(32'h0000_0020, 1, 0, 1'b0, 1'b0);

        // Randomized transfers with spurious acknowledges.
        spurious_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 12);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            ack_min = 0;
            ack_max = $urandom_range(0, 4);
            run_xfer($urandom, n, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
